// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 keyboard receiver that decodes game keys into held levels.
// Frames are 11 bits (start, 8 data LSB first, odd parity, stop) sampled on PS/2 clock falling edges.
module ps2_key_decoder #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       ps2Clk,
  input  logic       ps2Data,
  output logic       leftArrowPressed,
  output logic       rightArrowPressed,
  output logic       enterKeyPressed,
  output logic       spaceKeyPressed,
  output logic       newCode,
  output logic [7:0] scanCode,
  output logic       frameError
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
  logic                   clk_prev_q, clk_prev_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic                   parity_q, parity_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   ext_q, ext_d;
  logic                   brk_q, brk_d;
  logic                   left_q, left_d;
  logic                   right_q, right_d;
  logic                   enter_q, enter_d;
  logic                   space_q, space_d;
  logic                   new_code_q, new_code_d;
  logic [7:0]             scan_q, scan_d;
  logic                   frame_error_q, frame_error_d;

  logic clk_s, data_s, fall;
  assign clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign data_s = data_sync_q[SYNC_STAGES-1];
  assign fall   = clk_prev_q & ~clk_s;

  always_comb begin
    state_d       = state_q;
    clk_sync_d    = {clk_sync_q[SYNC_STAGES-2:0], ps2Clk};
    data_sync_d   = {data_sync_q[SYNC_STAGES-2:0], ps2Data};
    clk_prev_d    = clk_s;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    parity_d      = parity_q;
    cnt_d         = cnt_q;
    ext_d         = ext_q;
    brk_d         = brk_q;
    left_d        = left_q;
    right_d       = right_q;
    enter_d       = enter_q;
    space_d       = space_q;
    new_code_d    = 1'b0;
    scan_d        = scan_q;
    frame_error_d = 1'b0;

    if (fall) begin
      cnt_d = '0;
    end else if (state_q != IDLE) begin
      cnt_d = cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (fall) begin
          if (!data_s) begin
            state_d   = DATA;
            bit_cnt_d = 3'd0;
          end else begin
            frame_error_d = 1'b1;
          end
        end
      end
      DATA: begin
        if (fall) begin
          shift_d   = {data_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
      end
      PARITY: begin
        if (fall) begin
          parity_d = data_s;
          state_d  = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          state_d = IDLE;
          if (data_s && (^{shift_q, parity_q})) begin
            new_code_d = 1'b1;
            scan_d     = shift_q;
            if (shift_q == 8'hE0) begin
              ext_d = 1'b1;
            end else if (shift_q == 8'hF0) begin
              brk_d = 1'b1;
            end else begin
              if (shift_q == 8'h5A)               enter_d = !brk_q;
              else if (ext_q  && shift_q == 8'h6B) left_d  = !brk_q;
              else if (ext_q  && shift_q == 8'h74) right_d = !brk_q;
              else if (!ext_q && shift_q == 8'h29) space_d = !brk_q;
              ext_d = 1'b0;
              brk_d = 1'b0;
            end
          end else begin
            frame_error_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A stalled frame is abandoned and any half-received prefix forgotten.
    if (!fall && state_q != IDLE && cnt_q == TO_LAST) begin
      state_d       = IDLE;
      cnt_d         = '0;
      frame_error_d = 1'b1;
      ext_d         = 1'b0;
      brk_d         = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q       <= IDLE;
      clk_sync_q    <= '1;
      data_sync_q   <= '1;
      clk_prev_q    <= 1'b1;
      bit_cnt_q     <= 3'd0;
      shift_q       <= 8'h00;
      parity_q      <= 1'b0;
      cnt_q         <= '0;
      ext_q         <= 1'b0;
      brk_q         <= 1'b0;
      left_q        <= 1'b0;
      right_q       <= 1'b0;
      enter_q       <= 1'b0;
      space_q       <= 1'b0;
      new_code_q    <= 1'b0;
      scan_q        <= 8'h00;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      clk_sync_q    <= clk_sync_d;
      data_sync_q   <= data_sync_d;
      clk_prev_q    <= clk_prev_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      parity_q      <= parity_d;
      cnt_q         <= cnt_d;
      ext_q         <= ext_d;
      brk_q         <= brk_d;
      left_q        <= left_d;
      right_q       <= right_d;
      enter_q       <= enter_d;
      space_q       <= space_d;
      new_code_q    <= new_code_d;
      scan_q        <= scan_d;
      frame_error_q <= frame_error_d;
    end
  end

  assign leftArrowPressed  = left_q;
  assign rightArrowPressed = right_q;
  assign enterKeyPressed   = enter_q;
  assign spaceKeyPressed   = space_q;
  assign newCode           = new_code_q;
  assign scanCode          = scan_q;
  assign frameError        = frame_error_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb/tb_ps2_key_decoder.sv - directed PS/2 frames checked against a byte-level key model.
module tb_ps2_key_decoder;
  localparam int TO = 1000;

  logic       clk = 1'b0;
  logic       resetN, ps2Clk, ps2Data;
  logic       leftArrowPressed, rightArrowPressed, enterKeyPressed, spaceKeyPressed;
  logic       newCode, frameError;
  logic [7:0] scanCode;

  ps2_key_decoder #(.TIMEOUT_CYCLES(TO), .SYNC_STAGES(2)) dut (
    .clk(clk), .resetN(resetN), .ps2Clk(ps2Clk), .ps2Data(ps2Data),
    .leftArrowPressed(leftArrowPressed), .rightArrowPressed(rightArrowPressed),
    .enterKeyPressed(enterKeyPressed), .spaceKeyPressed(spaceKeyPressed),
    .newCode(newCode), .scanCode(scanCode), .frameError(frameError)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int nc_count = 0;
  int fe_count = 0;

  // Expected events: kind 0 = valid byte, 1 = bad frame (flags kept), 2 = timeout (flags cleared)
  int         ev_kind[$];
  logic [7:0] ev_byte[$];

  logic m_ext, m_brk, m_left, m_right, m_enter, m_space;
  logic [7:0] m_scan;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_ext = 0; m_brk = 0; m_left = 0; m_right = 0; m_enter = 0; m_space = 0;
    m_scan = 8'h00;
  endtask

  task automatic model_byte(input logic [7:0] b);
    m_scan = b;
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      case (b)
        8'h5A: m_enter = !m_brk;
        8'h6B: if (m_ext) m_left = !m_brk;
        8'h74: if (m_ext) m_right = !m_brk;
        8'h29: if (!m_ext) m_space = !m_brk;
        default: ;
      endcase
      m_ext = 0;
      m_brk = 0;
    end
  endtask

  always @(negedge clk) begin
    if (!resetN) begin
      model_clear();
      ev_kind.delete();
      ev_byte.delete();
      chk("reset_outputs",
          {leftArrowPressed, rightArrowPressed, enterKeyPressed, spaceKeyPressed,
           newCode, frameError, scanCode}, 0);
    end else begin
      if (newCode && frameError) chk("pulse_overlap", 1, 0);
      if (newCode) begin
        nc_count++;
        if (ev_kind.size() == 0) chk("unexpected_newcode", 1, 0);
        else begin
          chk("event_kind_newcode", 0, ev_kind.pop_front());
          chk("scan_on_newcode", scanCode, ev_byte[0]);
          model_byte(ev_byte.pop_front());
        end
      end else if (frameError) begin
        fe_count++;
        if (ev_kind.size() == 0) chk("unexpected_frameerror", 1, 0);
        else begin
          void'(ev_byte.pop_front());
          if (ev_kind[0] == 2) begin m_ext = 0; m_brk = 0; end
          chk("event_kind_frameerror", int'(ev_kind.pop_front() != 0), 1);
        end
      end
      chk("left",  leftArrowPressed,  m_left);
      chk("right", rightArrowPressed, m_right);
      chk("enter", enterKeyPressed,   m_enter);
      chk("space", spaceKeyPressed,   m_space);
      chk("scan",  scanCode,          m_scan);
    end
  end

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2Data = bits[i];
      repeat (10) @(posedge clk);
      ps2Clk = 1'b0;
      repeat (10) @(posedge clk);
      ps2Clk = 1'b1;
    end
    ps2Data = 1'b1;
    repeat (30) @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] frame(input logic [7:0] b, input logic corrupt);
    logic par;
    par = ~(^b) ^ corrupt;
    return {1'b1, par, b, 1'b0};
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic corrupt = 1'b0);
    ev_kind.push_back(corrupt ? 1 : 0);
    ev_byte.push_back(b);
    send_bits(frame(b, corrupt), 11);
  endtask

  int nc0, fe0;

  initial begin
    resetN = 1'b0; ps2Clk = 1'b1; ps2Data = 1'b1;
    repeat (5) @(posedge clk);
    #1 resetN = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("lit_reset_scan", scanCode, 8'h00);

    send_byte(8'hE0); send_byte(8'h6B);
    chk("lit_left_make", leftArrowPressed, 1);
    chk("lit_scan_6b", scanCode, 8'h6B);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h6B);
    chk("lit_left_break", leftArrowPressed, 0);

    send_byte(8'h5A);
    chk("lit_enter_make", enterKeyPressed, 1);
    send_byte(8'hF0); send_byte(8'h5A);
    chk("lit_enter_break", enterKeyPressed, 0);
    send_byte(8'hE0); send_byte(8'h5A);
    chk("lit_kpenter_make", enterKeyPressed, 1);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h5A);
    chk("lit_kpenter_break", enterKeyPressed, 0);

    nc0 = nc_count;
    send_byte(8'h6B);
    chk("lit_kp4_newcode", nc_count - nc0, 1);
    chk("lit_kp4_left", leftArrowPressed, 0);

    nc0 = nc_count; fe0 = fe_count;
    send_byte(8'h29, 1'b1);
    chk("lit_parity_fe", fe_count - fe0, 1);
    chk("lit_parity_nc", nc_count - nc0, 0);
    chk("lit_parity_space", spaceKeyPressed, 0);
    send_byte(8'h29);
    chk("lit_space_make", spaceKeyPressed, 1);

    fe0 = fe_count;
    ev_kind.push_back(2); ev_byte.push_back(8'h00);
    send_bits(frame(8'hE0, 1'b0), 4);
    repeat (TO + 50) @(posedge clk);
    #1;
    chk("lit_timeout_fe", fe_count - fe0, 1);
    send_byte(8'h74);
    chk("lit_timeout_right", rightArrowPressed, 0);
    chk("lit_timeout_scan", scanCode, 8'h74);

    send_byte(8'hE0); send_byte(8'h74);
    chk("lit_right_make", rightArrowPressed, 1);
    send_byte(8'h29);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h74);
    chk("lit_right_break", rightArrowPressed, 0);
    chk("lit_space_held", spaceKeyPressed, 1);

    send_bits(frame(8'h5A, 1'b0), 5);
    @(posedge clk); #2 resetN = 1'b0;
    @(negedge clk); #1;
    chk("lit_async_reset_space", spaceKeyPressed, 0);
    repeat (3) @(posedge clk);
    #1 resetN = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    send_byte(8'h5A);
    chk("lit_after_reset_enter", enterKeyPressed, 1);

    nc0 = nc_count;
    for (int k = 0; k < 5; k++) begin
      send_byte(8'hE0); send_byte(8'h74);
      chk("lit_typematic_right", rightArrowPressed, 1);
    end
    chk("lit_typematic_count", nc_count - nc0, 10);

    repeat (20) @(posedge clk);
    chk("events_drained", ev_kind.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Receives the raw PS/2 keyboard serial stream and turns it into level signals for each game key.
- Outputs are left arrow, right arrow, enter and space; each stays high while its key is held.
- These levels drive the player movement/start logic and the shot logic directly, once per system clock.
- Also exposes each completed scan byte and a frame-error pulse for debug/LEDs.

Parameters:
- TIMEOUT_CYCLES, 50000: system clocks with no PS/2 falling edge mid-frame before the receiver abandons the frame (1 ms at 50 MHz).
- SYNC_STAGES, 2: flip-flop synchroniser depth on ps2Clk and ps2Data (minimum 2).

Ports:
- clk  input  1  system clock
- resetN  input  1  asynchronous active-low reset
- ps2Clk  input  1  PS/2 clock line, asynchronous to clk
- ps2Data  input  1  PS/2 data line, asynchronous to clk
- leftArrowPressed  output  1  high while left arrow (E0 6B) is held
- rightArrowPressed  output  1  high while right arrow (E0 74) is held
- enterKeyPressed  output  1  high while Enter (5A, or keypad enter E0 5A) is held
- spaceKeyPressed  output  1  high while Space (29) is held
- newCode  output  1  one-cycle pulse when a valid byte completes
- scanCode  output  8  last valid byte; updated together with newCode
- frameError  output  1  one-cycle pulse on parity error, bad start/stop bit, or timeout

Behaviour:
- Reset: all outputs are 0, scanCode is 8'h00, the receive FSM is in IDLE, and the prefix flags are cleared. Reset applies immediately and may land mid-frame; the partial frame is discarded.
- Synchronisation: ps2Clk and ps2Data each pass through SYNC_STAGES flip-flops. A falling edge is the synchronised clock going 1 then 0 on consecutive cycles. Data is sampled in the edge-detect cycle.
- Receive FSM:
  - IDLE: on a falling edge with data=0 (start bit), go to DATA and clear the bit counter. On a falling edge with data=1, stay in IDLE and pulse frameError.
  - DATA: shift in 8 bits, LSB first, one per falling edge. After bit 7, go to PARITY.
  - PARITY: capture the parity bit, then go to STOP.
  - STOP: on a falling edge, check stop bit = 1 and odd parity (8 data bits plus parity contain an odd number of 1s).
    - Pass: next cycle pulse newCode, load scanCode, run the decoder.
    - Fail: next cycle pulse frameError; byte discarded, key levels and prefix flags unchanged.
    - Either way, return to IDLE.
- Timeout: a counter clears on every falling edge and counts while the FSM is not in IDLE. When it reaches TIMEOUT_CYCLES-1, the FSM returns to IDLE, frameError pulses, and prefix flags clear.
- Decoder (runs only on a valid byte):
  - E0: set the ext flag.
  - F0: set the brk flag.
  - Any other byte: look up the key with the ext flag.
    - Key level ← !brk.
    - ext and brk then clear.
    - Unmapped codes only clear the flags.
  - Mapping:
    - ext=1, 6B → left
    - ext=1, 74 → right
    - 5A with either ext value → enter
    - ext=0, 29 → space
    - ext=0, 6B or 74 (keypad 4/6) → unmapped
- Latency: key levels change in the same cycle as the newCode pulse, i.e. 1 clk after the stop-bit edge is detected. Stop-bit edge detection itself is SYNC_STAGES+1 clks after the physical edge.
- Typematic repeats (repeated make codes) leave the level high; no toggling.
- Keys are independent: left and right may be high together, and resolving that is the consumer's job.
- newCode and frameError never pulse in the same cycle. Neither pulses for longer than one cycle.

Test Plan:
- Make then break of left arrow:
  - Send E0,6B → leftArrowPressed=1 in the newCode cycle of 6B; scanCode=6B.
  - Send E0,F0,6B → leftArrowPressed=0; other keys stay 0 throughout.
- Enter, both variants:
  - Send 5A → enterKeyPressed=1; send F0,5A → 0.
  - Repeat with E0 5A / E0 F0 5A → same result.
  - Send 6B with no E0 → no key changes, newCode still pulses.
- Corrupted byte: send 29 with the parity bit flipped → frameError pulses once, no newCode, spaceKeyPressed stays 0. The following correct 29 sets spaceKeyPressed=1.
- Timeout: send start bit plus 3 data bits of E0, then hold ps2Clk high for TIMEOUT_CYCLES clks → frameError pulses, FSM back in IDLE, ext flag clear. A subsequent 74 (no E0) leaves rightArrowPressed=0.
- Simultaneous keys: make right (E0 74), make space (29), break right (E0 F0 74) → right 1→0 while space stays 1. Then pulse resetN low mid-frame → all outputs 0 at once, and the next full frame decodes correctly.
- Typematic: send E0 74 five times → rightArrowPressed stays 1 and newCode pulses 10 times.
